rf_sequencer: RTL and testbench
===============================

Name: rf_sequencer

Overview:
- Initiator side of the 8×16 register-file port set: a fetch/decode/execute control FSM for the cpu16 core.
- Drives the register file's read addresses, write port and PC count-enable.
- Fetches instructions over a req/ack memory handshake, executes a small ALU/immediate/jump subset, and writes results back.
- The register file has no reset, so this block initialises the PC (r7) itself.

Parameters:
RESET_PC, 16'h0000, value written to r7 in the first cycle after reset release

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  synchronous active-low reset
o_mem_req  output  1  instruction fetch request
o_mem_addr  output  16  fetch address (= i_program_counter while requesting)
i_mem_ack  input  1  fetch complete; i_mem_rdata valid this cycle
i_mem_rdata  input  16  instruction word
o_rf_read_addr1  output  3  register file read address 1 (rs1)
o_rf_read_addr2  output  3  register file read address 2 (rs2)
i_rf_read_data1  input  16  combinational read data 1
i_rf_read_data2  input  16  combinational read data 2
i_program_counter  input  16  current r7
o_rf_write_enable  output  1  register write strobe
o_rf_write_address  output  3  write address
o_rf_write_data  output  16  write data
o_rf_count_enable  output  1  PC increment strobe
o_halted  output  1  high in HALT state

Behaviour:
- Reset: while i_rst_n=0 at a rising edge → state INIT, instr reg=0, result reg=0. All write/req/count outputs deassert in the cycle after that edge. Reset mid-fetch abandons the request; a late ack is ignored.
- Instruction format: [15:12] op, [11:9] rd, [8:6] rs1, [5:3] rs2, [8:0] imm9.
- Opcodes:
  - 0 ADD: rd=rs1+rs2
  - 1 SUB: rd=rs1-rs2
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 LDI: rd=sign-extend(imm9)
  - 6 JMP: r7=rs1
  - F HALT
  - 7–E: NOP, no write
- Arithmetic is modulo 2^16; carry and borrow are discarded.
- States:
  - INIT (1 cycle): write_enable=1, address=7, data=RESET_PC → FETCH.
  - FETCH: o_mem_req=1, o_mem_addr=i_program_counter; hold req and addr stable until ack (any number of wait cycles).
    - In the ack cycle: latch i_mem_rdata into the instr reg and assert o_rf_count_enable=1 for exactly that cycle (PC+1 at the edge) → DECODE.
    - count_enable is never asserted outside this cycle.
  - DECODE (1 cycle): read addrs are driven from instr reg[8:6]/[5:3] (driven continuously from the instr reg in all states). Compute the result from i_rf_read_data1/2 and register it → EXECUTE.
  - EXECUTE (1 cycle):
    - ALU or LDI: write_enable=1, address=rd, data=result.
    - JMP: write to address 7 with the rs1 value.
    - NOP: no write.
    - Next state: HALT if op=F, else FETCH.
  - HALT: o_halted=1; no req/write/count; exits only by reset.
- Throughput: 3 cycles per instruction with zero-wait memory (FETCH, DECODE, EXECUTE).
- Writes to rd=0 are still issued; the register file discards them.
- ALU write with rd=7 acts as a computed jump. PC-relative reads of r7 in DECODE see the already-incremented PC.
- write_enable and count_enable are never high in the same cycle.
- o_mem_req=0 in every state except FETCH. An ack while req=0 is ignored.

Test Plan:
- Reset with RESET_PC=16'h0040, release → one cycle write r7←0x0040, then o_mem_req=1 with o_mem_addr=0x0040.
- Zero-wait fetch of LDI r1,-1 (0x53FF) → count_enable pulses once in the ack cycle; 2 cycles later write r1←0xFFFF; next fetch addr 0x0041.
- r1=0x7FFF, r2=0x0001, ADD r3,r1,r2 (0x0650) → write r3←0x8000. SUB r4,r2,r1 → 0x8002.
- Ack delayed 3 cycles → req/addr stable for 4 cycles, count_enable high only in the ack cycle, no write during wait.
- JMP r1 (r1=0x0100) → EXECUTE writes r7←0x0100, count_enable=0 that cycle, next fetch addr 0x0100.
- HALT (0xF000) → o_halted=1, no further req over 20 cycles. Reset asserted during a pending fetch → no count_enable, INIT follows release.

Source files
------------

// File: rtl/rf_sequencer.sv
// Fetch/decode/execute control FSM for the cpu16 core. It drives the register file's read
// addresses, write port and PC count-enable, and fetches over a req/ack memory handshake.
module rf_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_mem_req,
  output logic [15:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [15:0] i_mem_rdata,
  output logic [2:0]  o_rf_read_addr1,
  output logic [2:0]  o_rf_read_addr2,
  input  logic [15:0] i_rf_read_data1,
  input  logic [15:0] i_rf_read_data2,
  input  logic [15:0] i_program_counter,
  output logic        o_rf_write_enable,
  output logic [2:0]  o_rf_write_address,
  output logic [15:0] o_rf_write_data,
  output logic        o_rf_count_enable,
  output logic        o_halted
);

  typedef enum logic [2:0] {StInit, StFetch, StDecode, StExecute, StHalt} state_e;

  state_e      state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] result_q, result_d;
  logic [15:0] alu_result;
  logic [3:0]  op;
  logic [2:0]  rd;

  assign op              = instr_q[15:12];
  assign rd              = instr_q[11:9];
  assign o_rf_read_addr1 = instr_q[8:6];
  assign o_rf_read_addr2 = instr_q[5:3];

  always_comb begin
    alu_result = '0;
    case (op)
      4'h0:    alu_result = i_rf_read_data1 + i_rf_read_data2;
      4'h1:    alu_result = i_rf_read_data1 - i_rf_read_data2;
      4'h2:    alu_result = i_rf_read_data1 & i_rf_read_data2;
      4'h3:    alu_result = i_rf_read_data1 | i_rf_read_data2;
      4'h4:    alu_result = i_rf_read_data1 ^ i_rf_read_data2;
      4'h5:    alu_result = {{7{instr_q[8]}}, instr_q[8:0]};
      4'h6:    alu_result = i_rf_read_data1;
      default: alu_result = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= StInit;
      instr_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    instr_d            = instr_q;
    result_d           = result_q;
    o_mem_req          = 1'b0;
    o_mem_addr         = '0;
    o_rf_write_enable  = 1'b0;
    o_rf_write_address = '0;
    o_rf_write_data    = '0;
    o_rf_count_enable  = 1'b0;
    o_halted           = 1'b0;
    // Outputs stay quiet while reset is held so INIT only writes r7 once reset is released.
    if (i_rst_n) begin
      unique case (state_q)
        StInit: begin
          o_rf_write_enable  = 1'b1;
          o_rf_write_address = 3'd7;
          o_rf_write_data    = RESET_PC;
          state_d            = StFetch;
        end
        StFetch: begin
          o_mem_req  = 1'b1;
          o_mem_addr = i_program_counter;
          if (i_mem_ack) begin
            instr_d           = i_mem_rdata;
            o_rf_count_enable = 1'b1;
            state_d           = StDecode;
          end
        end
        StDecode: begin
          result_d = alu_result;
          state_d  = StExecute;
        end
        StExecute: begin
          if (op <= 4'h5) begin
            o_rf_write_enable  = 1'b1;
            o_rf_write_address = rd;
            o_rf_write_data    = result_q;
          end else if (op == 4'h6) begin
            o_rf_write_enable  = 1'b1;
            o_rf_write_address = 3'd7;
            o_rf_write_data    = result_q;
          end
          state_d = (op == 4'hF) ? StHalt : StFetch;
        end
        StHalt: begin
          o_halted = 1'b1;
        end
        default: state_d = StInit;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_sequencer.sv
// Directed bench for rf_sequencer: a behavioural register file and memory responder surround
// the DUT, and expected register writes are queued at fetch time and checked as they appear.
module tb_rf_sequencer;

  typedef struct packed {
    logic [2:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic [2:0]  ra1, ra2;
  logic [15:0] rd1, rd2, pc;
  logic        we;
  logic [2:0]  wa;
  logic [15:0] wd;
  logic        cnt;
  logic        halted;

  logic [15:0] regs [8];
  logic        poke_en = 1'b0;
  logic [2:0]  poke_addr = '0;
  logic [15:0] poke_data = '0;

  wr_t exp_q [$];
  int  total = 0;
  int  bad = 0;

  always #5 clk = ~clk;

  rf_sequencer #(.RESET_PC(16'h0040)) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .o_mem_req          (mem_req),
    .o_mem_addr         (mem_addr),
    .i_mem_ack          (mem_ack),
    .i_mem_rdata        (mem_rdata),
    .o_rf_read_addr1    (ra1),
    .o_rf_read_addr2    (ra2),
    .i_rf_read_data1    (rd1),
    .i_rf_read_data2    (rd2),
    .i_program_counter  (pc),
    .o_rf_write_enable  (we),
    .o_rf_write_address (wa),
    .o_rf_write_data    (wd),
    .o_rf_count_enable  (cnt),
    .o_halted           (halted)
  );

  // Register file model: no reset, combinational reads, r7 counts on the strobe.
  initial for (int i = 0; i < 8; i++) regs[i] = '0;
  assign rd1 = regs[ra1];
  assign rd2 = regs[ra2];
  assign pc  = regs[7];

  always @(posedge clk) begin
    if (we) regs[wa] <= wd;
    else if (cnt) regs[7] <= regs[7] + 16'd1;
    if (poke_en) regs[poke_addr] <= poke_data;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Write monitor: every write must match the oldest expected one.
  always @(negedge clk) begin
    #2;
    if (we) begin
      chk("wr_with_count", {15'd0, cnt}, 16'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {13'd0, wa}, 16'hFFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", {13'd0, wa}, {13'd0, e.addr});
        chk("wr_data", wd, e.data);
      end
    end
  end

  task automatic expect_wr(input logic [2:0] a, input logic [15:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_req(input logic [15:0] exp_addr);
    int n = 0;
    @(negedge clk); #1;
    while (!mem_req && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    chk("req_seen", {15'd0, mem_req}, 16'd1);
    chk("fetch_addr", mem_addr, exp_addr);
  endtask

  task automatic give_ack(input logic [15:0] instr, input int waits, input logic [15:0] addr);
    for (int j = 0; j < waits; j++) begin
      chk("wait_count", {15'd0, cnt}, 16'd0);
      chk("wait_we", {15'd0, we}, 16'd0);
      @(negedge clk); #1;
      chk("wait_req", {15'd0, mem_req}, 16'd1);
      chk("wait_addr", mem_addr, addr);
    end
    mem_rdata = instr;
    mem_ack   = 1'b1;
    #1;
    chk("ack_count", {15'd0, cnt}, 16'd1);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk("post_ack_count", {15'd0, cnt}, 16'd0);
    chk("post_ack_req", {15'd0, mem_req}, 16'd0);
  endtask

  initial begin
    // Reset held: everything quiet.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_we", {15'd0, we}, 16'd0);
    chk("rst_req", {15'd0, mem_req}, 16'd0);
    chk("rst_cnt", {15'd0, cnt}, 16'd0);
    chk("rst_halted", {15'd0, halted}, 16'd0);
    expect_wr(3'd7, 16'h0040);
    @(negedge clk);
    rst_n = 1'b1;

    wait_req(16'h0040);
    give_ack(16'h53FF, 0, 16'h0040);          // LDI r1,-1
    expect_wr(3'd1, 16'hFFFF);

    wait_req(16'h0041);
    poke_en = 1'b1; poke_addr = 3'd1; poke_data = 16'h7FFF;
    @(negedge clk); poke_addr = 3'd2; poke_data = 16'h0001;
    @(negedge clk); poke_en = 1'b0;
    #1;
    give_ack(16'h0650, 0, 16'h0041);          // ADD r3,r1,r2
    expect_wr(3'd3, 16'h8000);

    wait_req(16'h0042);
    give_ack(16'h1888, 3, 16'h0042);          // SUB r4,r2,r1 with 3 wait cycles
    expect_wr(3'd4, 16'h8002);

    wait_req(16'h0043);
    give_ack(16'h2A58, 0, 16'h0043);          // AND r5,r1,r3
    expect_wr(3'd5, 16'h0000);
    wait_req(16'h0044);
    give_ack(16'h3C58, 0, 16'h0044);          // OR r6,r1,r3
    expect_wr(3'd6, 16'hFFFF);
    wait_req(16'h0045);
    give_ack(16'h4B10, 0, 16'h0045);          // XOR r5,r4,r2
    expect_wr(3'd5, 16'h8003);
    wait_req(16'h0046);
    give_ack(16'h54FF, 1, 16'h0046);          // LDI r2,+255
    expect_wr(3'd2, 16'h00FF);
    wait_req(16'h0047);
    give_ack(16'h7FFF, 0, 16'h0047);          // NOP

    wait_req(16'h0048);
    poke_en = 1'b1; poke_addr = 3'd1; poke_data = 16'h0100;
    @(negedge clk); poke_en = 1'b0;
    #1;
    give_ack(16'h6040, 0, 16'h0048);          // JMP r1
    expect_wr(3'd7, 16'h0100);

    wait_req(16'h0100);
    give_ack(16'hF000, 0, 16'h0100);          // HALT
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("halted", {15'd0, halted}, 16'd1);
    for (int k = 0; k < 20; k++) begin
      mem_ack = k[0];
      @(negedge clk); #1;
      chk("halt_req", {15'd0, mem_req}, 16'd0);
      chk("halt_cnt", {15'd0, cnt}, 16'd0);
      chk("halt_hold", {15'd0, halted}, 16'd1);
    end
    mem_ack = 1'b0;

    // Reset out of HALT, then reset again in the middle of a pending fetch.
    rst_n = 1'b0;
    @(negedge clk); #1;
    chk("rst2_halted", {15'd0, halted}, 16'd0);
    expect_wr(3'd7, 16'h0040);
    rst_n = 1'b1;
    wait_req(16'h0040);
    @(negedge clk);
    rst_n = 1'b0;
    mem_rdata = 16'h5A01;
    mem_ack = 1'b1;
    #1;
    chk("rst_ack_cnt", {15'd0, cnt}, 16'd0);
    @(negedge clk); #1;
    chk("rst_hold_cnt", {15'd0, cnt}, 16'd0);
    chk("rst_hold_req", {15'd0, mem_req}, 16'd0);
    expect_wr(3'd7, 16'h0040);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("late_ack_cnt", {15'd0, cnt}, 16'd0);
    chk("late_ack_req", {15'd0, mem_req}, 16'd0);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk("refetch_req", {15'd0, mem_req}, 16'd1);
    chk("refetch_addr", mem_addr, 16'h0040);
    give_ack(16'h5A01, 0, 16'h0040);          // LDI r5,1
    expect_wr(3'd5, 16'h0001);
    repeat (4) @(negedge clk);
    #3;
    chk("pending_writes", exp_q.size()[15:0], 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
